filter_output_capture: RTL
==========================

Name: filter_output_capture

Overview:
- Synthesizable capture engine at the output of the filter datapath. It is the on-chip reader for the filter's sample stream.
- It records a frame of N filter output samples, qualified by clk_en, into an internal buffer. It then drains them to a host/readout path over a valid/ready handshake.
- Each sample is sign-extended to 32 bits, so bench and hardware results are directly comparable against the same golden lists.

Parameters:
- N, 4096, samples per frame.
- AW, 12, buffer address width; N must equal 2**AW.
- DW, 16, filter output width.
- OW, 32, readout width, sign-extended from DW.
- SKIP, 0, enabled samples discarded after start (covers filter pipeline latency).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk).
- clk_en  in  1  sample qualifier; yout is valid only when high.
- start  in  1  single-cycle pulse; arms a capture.
- yout  in  DW  signed filter output.
- busy  out  1  high in SKIP, CAPTURE and DRAIN.
- done  out  1  one-cycle pulse after the last word is accepted.
- wr_count  out  AW+1  samples written in the current frame (0..N).
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer accepts the word when high with rd_valid.
- rd_data  out  OW  sign-extended sample.
- rd_index  out  AW  buffer index of the current rd_data.

Behaviour:
- Reset values (rst low): state IDLE; busy 0; done 0; wr_count 0; rd_valid 0; rd_data 0; rd_index 0. Buffer contents are not cleared.
- States: IDLE, SKIP, CAPTURE, DRAIN.
- IDLE:
  - start=1 goes to SKIP, or to CAPTURE directly if SKIP==0.
  - wr_count clears to 0 on that edge.
- SKIP: counts SKIP cycles with clk_en=1, discarding yout. The edge that consumes the SKIP-th enabled sample moves to CAPTURE.
- CAPTURE:
  - Each clk_en=1 cycle writes {{(OW-DW){yout[DW-1]}}, yout} to buffer[wr_count] and increments wr_count.
  - clk_en=0 cycles write nothing.
  - The edge writing sample N-1 (wr_count becomes N) moves to DRAIN.
- DRAIN:
  - Buffer is a synchronous-read RAM. A 2-entry prefetch/skid stage sustains 1 word/cycle.
  - rd_valid rises at the 2nd rising edge after the edge that wrote sample N-1.
  - Words are presented in index order 0..N-1; rd_index matches the word.
  - While rd_valid=1 and rd_ready=0, rd_data and rd_index hold stable.
  - If rd_ready is held high, one word transfers per cycle with no bubbles.
  - Accepting index N-1: rd_valid drops on the next edge, done pulses for exactly 1 cycle, state returns to IDLE.
- start outside IDLE is ignored: no restart and no state change. start in the same cycle done is high is also ignored; the block enters IDLE only after done.
- clk_en is ignored in DRAIN and IDLE; no writes occur.
- rst low mid-frame: immediate return to IDLE; the partial frame is discarded; the next start begins at index 0.
- Arithmetic: the sign extension is purely replication of yout[DW-1]; no rounding or saturation.
- wr_count is AW+1 wide, so it reaches N without wrapping. The read index wraps nowhere because the frame ends at N-1.

Decomposition:
- Package filter_capture_pkg holds:
  - the state enum (IDLE, SKIP, CAPTURE, DRAIN);
  - localparams for default N/AW/DW/OW;
  - a sign-extension function.
- One sub-module, capture_ram: single-port write, synchronous-read RAM, N x OW, with separate read/write addresses (simple dual-port), inferable as block RAM.
- The FSM, counters and prefetch/skid stage live in the top.

Test Plan:
1. Reset, start, clk_en=1 continuously, yout ramp 0..N-1, rd_ready=1 -> rd_data k on index k for k=0..4095 in consecutive cycles; done pulses once; busy falls with done.
2. Negative samples: yout=16'h8000, then 16'hFFFF, then 16'h7FFF -> rd_data 32'hFFFF8000, 32'hFFFFFFFF, 32'h00007FFF.
3. clk_en toggling 1,0,1,0 with yout incremented every cycle, N=8 build -> only even-cycle values captured; wr_count reaches 8 after 16 enabled-window cycles.
4. SKIP=3, yout = 10,11,12,... with clk_en=1 -> first captured word is 13; rd_index 0 carries 13.
5. rd_ready held low 5 cycles at index 2, then high -> rd_data/rd_index hold index 2 value for the stall; no word lost or duplicated; sequence continues 3,4,...
6. rst pulled low at wr_count=100, released, then new start with yout=500+k -> busy 0 immediately on reset; new frame index 0 = 500; a start pulse issued during DRAIN has no effect.

Source files
------------

// File: rtl/filter_capture_pkg.sv
// Shared types and helpers for the filter output capture engine.
// Holds the FSM state encoding, default geometry and sign extension.
package filter_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SKIP,
      ST_CAPTURE,
      ST_DRAIN
   } cap_state_t;

   localparam int N_DEF  = 4096;
   localparam int AW_DEF = 12;
   localparam int DW_DEF = 16;
   localparam int OW_DEF = 32;

   // Replicates bit dw-1 of raw into every bit above it.
   function automatic logic [OW_DEF-1:0] sign_extend(
      input logic [OW_DEF-1:0] raw,
      input int                dw
   );
      logic [OW_DEF-1:0] r;
      r = '0;
      for (int i = 0; i < OW_DEF; i++) begin
         r[i] = (i < dw) ? raw[i] : raw[dw-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Frame buffer: one write port, one synchronous read port.
// No reset on the array or read register so it maps onto block RAM.
module capture_ram #(
   parameter int AW = 12,
   parameter int OW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [OW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [OW-1:0] rdata
);

   logic [OW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/filter_output_capture.sv
// Captures one frame of clk_en-qualified filter samples, then drains
// it in index order over a valid/ready port at up to one word per cycle.
module filter_output_capture
   import filter_capture_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF,
   parameter int OW   = OW_DEF,
   parameter int SKIP = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_en,
   input  logic          start,
   input  logic [DW-1:0] yout,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   wr_count,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [OW-1:0] rd_data,
   output logic [AW-1:0] rd_index
);

   localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
   localparam logic [AW:0]   LAST_WR = (AW+1)'(N - 1);
   localparam logic [AW-1:0] LAST_RD = AW'(N - 1);

   cap_state_t state;
   logic [SW-1:0] skip_cnt;

   logic          we;
   logic [OW_DEF-1:0] ext_full;
   logic [OW-1:0] wdata;

   logic [AW:0]   rd_addr;
   logic          issue;
   logic          ram_vld;
   logic [AW-1:0] ram_idx;
   logic [OW-1:0] ram_q;

   logic          skid_v;
   logic [OW-1:0] skid_data;
   logic [AW-1:0] skid_idx;

   logic          pop;
   logic          last_acc;
   logic [1:0]    occ;

   assign we       = (state == ST_CAPTURE) & clk_en;
   assign ext_full = sign_extend(OW_DEF'(yout), DW);
   assign wdata    = ext_full[OW-1:0];

   assign pop      = rd_valid & rd_ready;
   assign last_acc = pop & (rd_index == LAST_RD);

   // Words held or in flight after this cycle's pop; at most two fit.
   assign occ = {1'b0, rd_valid} + {1'b0, skid_v}
              + {1'b0, ram_vld} - {1'b0, pop};

   assign issue = (state == ST_DRAIN) & ~rd_addr[AW] & (occ < 2'd2);

   capture_ram #(
      .AW (AW),
      .OW (OW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr_count[AW-1:0]),
      .wdata (wdata),
      .re    (issue),
      .raddr (rd_addr[AW-1:0]),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_count <= '0;
         skip_cnt <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && !done) begin
                  wr_count <= '0;
                  skip_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (clk_en) begin
                  if (skip_cnt == SW'(SKIP - 1)) begin
                     state <= ST_CAPTURE;
                  end else begin
                     skip_cnt <= skip_cnt + 1'b1;
                  end
               end
            end
            ST_CAPTURE: begin
               if (clk_en) begin
                  wr_count <= wr_count + 1'b1;
                  if (wr_count == LAST_WR) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (last_acc) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr   <= '0;
         ram_vld   <= 1'b0;
         ram_idx   <= '0;
         skid_v    <= 1'b0;
         skid_data <= '0;
         skid_idx  <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         rd_index  <= '0;
      end else begin
         ram_vld <= issue;
         if (state == ST_IDLE) begin
            rd_addr <= '0;
         end else if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            ram_idx <= rd_addr[AW-1:0];
         end
         // Skid entry is older than the RAM word, so it drains first.
         if (!rd_valid || rd_ready) begin
            if (skid_v) begin
               rd_valid <= 1'b1;
               rd_data  <= skid_data;
               rd_index <= skid_idx;
               skid_v   <= ram_vld;
               if (ram_vld) begin
                  skid_data <= ram_q;
                  skid_idx  <= ram_idx;
               end
            end else if (ram_vld) begin
               rd_valid <= 1'b1;
               rd_data  <= ram_q;
               rd_index <= ram_idx;
            end else begin
               rd_valid <= 1'b0;
            end
         end else if (ram_vld) begin
            skid_v    <= 1'b1;
            skid_data <= ram_q;
            skid_idx  <= ram_idx;
         end
      end
   end

endmodule
